// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Memory-side responder for the core's data SRAM port. Requests are served
//   from an internal word-addressed RAM, or from a small I/O register file
//   (LEDs, switches, compare timer) when addr[31:16] == IO_HI.
//   Read data is registered: one cycle of latency, one request per cycle.
//
// Ports
//   clk             : sole clock, rising edge
//   rst             : synchronous active-high reset
//   data_sram_en    : request valid
//   data_sram_we    : byte write enables (0 = read)
//   data_sram_addr  : byte address, bits [1:0] ignored
//   data_sram_wdata : lane-aligned write data
//   data_sram_rdata : registered read data
//   sw              : switch inputs
//   led             : LED register
//   int_req         : timer interrupt request (level)
module data_sram_responder #(
   parameter int          RAM_AW = 12,
   parameter logic [15:0] IO_HI  = 16'hBFAF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_we,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   input  logic [7:0]  sw,
   output logic [15:0] led,
   output logic        int_req
);

   localparam logic [15:0] OFF_LED    = 16'h0000;
   localparam logic [15:0] OFF_SW     = 16'h0004;
   localparam logic [15:0] OFF_TCOUNT = 16'h0008;
   localparam logic [15:0] OFF_TCMP   = 16'h000C;
   localparam logic [15:0] OFF_CTRL   = 16'h0010;
   localparam logic [15:0] OFF_STAT   = 16'h0014;

   logic [31:0] mem [0:(1<<RAM_AW)-1];

   logic [31:0] tcount;
   logic [31:0] tcmp;
   logic [1:0]  ctrl;
   logic        pending;

   logic              io;
   logic [15:0]       off;
   logic [RAM_AW-1:0] ram_idx;
   logic              req;
   logic              ram_wr;
   logic              io_wr;
   logic              match;
   logic [31:0]       io_rdata;
   logic              unused_ok;

   // A request coinciding with reset is dropped entirely.
   assign req     = data_sram_en && !rst;
   assign io      = (data_sram_addr[31:16] == IO_HI);
   assign off     = {data_sram_addr[15:2], 2'b00};
   assign ram_idx = data_sram_addr[RAM_AW+1:2];
   assign ram_wr  = req && !io && (data_sram_we != 4'h0);
   // Partial-width I/O stores are ignored to avoid half-updated registers.
   assign io_wr   = req && io && (data_sram_we == 4'hF);
   assign match   = ctrl[0] && (tcount == tcmp);
   assign int_req = pending & ctrl[1];

   assign unused_ok = &{1'b0, data_sram_addr[1:0]};

   always_comb begin
      io_rdata = 32'h0;
      case (off)
         OFF_LED:    io_rdata = {16'h0, led};
         OFF_SW:     io_rdata = {24'h0, sw};
         OFF_TCOUNT: io_rdata = tcount;
         OFF_TCMP:   io_rdata = tcmp;
         OFF_CTRL:   io_rdata = {30'h0, ctrl};
         OFF_STAT:   io_rdata = {31'h0, pending};
         default:    io_rdata = 32'h0;
      endcase
   end

   // RAM: not reset; the read below sees pre-write contents (read-first).
   always_ff @(posedge clk) begin
      if (ram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_we[i]) mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_sram_rdata <= 32'h0;
      end else if (data_sram_en) begin
         data_sram_rdata <= io ? io_rdata : mem[ram_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led  <= 16'h0;
         tcmp <= 32'hFFFF_FFFF;
         ctrl <= 2'b00;
      end else if (io_wr) begin
         if (off == OFF_LED)  led  <= data_sram_wdata[15:0];
         if (off == OFF_TCMP) tcmp <= data_sram_wdata;
         if (off == OFF_CTRL) ctrl <= data_sram_wdata[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tcount <= 32'h0;
      end else if (io_wr && off == OFF_TCOUNT) begin
         tcount <= data_sram_wdata;
      end else if (ctrl[0]) begin
         tcount <= tcount + 32'd1;
      end
   end

   // A match in the same cycle as a W1C clear keeps pending set.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
      end else if (match) begin
         pending <= 1'b1;
      end else if (io_wr && off == OFF_STAT && data_sram_wdata[0]) begin
         pending <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// Testbench for data_sram_responder: scenario tasks with a queue of expected
// read data pushed at request time and popped one cycle later.
module tb_data_sram_responder;

   logic        clk;
   logic        rst;
   logic        en;
   logic [3:0]  we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  sw;
   logic [15:0] led;
   logic        int_req;

   int vectors = 0;
   int errors  = 0;
   logic [31:0] sb [$];
   logic [31:0] exp_v;

   localparam logic [31:0] IO = 32'hBFAF_0000;

   data_sram_responder dut (
      .clk(clk), .rst(rst),
      .data_sram_en(en), .data_sram_we(we), .data_sram_addr(addr),
      .data_sram_wdata(wdata), .data_sram_rdata(rdata),
      .sw(sw), .led(led), .int_req(int_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Present one request for one edge, then sample 1ns after that edge.
   task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
      en = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk); #1;
      en = 1'b0; we = 4'h0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      vectors++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0); end
      vectors++;
      if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h want %h", led, 16'h0); end
      vectors++;
      if (int_req !== 1'b0) begin errors++; $display("FAIL reset_int: got %b want 0", int_req); end
      sb.push_back(32'hFFFF_FFFF);
      req(4'h0, IO | 32'h0C, 32'h0);
      exp_v = sb.pop_front(); vectors++;
      if (rdata !== exp_v) begin errors++; $display("FAIL reset_tcmp: got %h want %h", rdata, exp_v); end
      sb.push_back(32'h0);
      req(4'h0, IO | 32'h08, 32'h0);
      exp_v = sb.pop_front(); vectors++;
      if (rdata !== exp_v) begin errors++; $display("FAIL reset_tcount: got %h want %h", rdata, exp_v); end
   endtask

   task automatic test_ram_lanes;
      req(4'hF, 32'h0000_0100, 32'h1122_3344);
      req(4'b0101, 32'h0000_0100, 32'hAABB_CCDD);
      sb.push_back(32'h11BB_33DD);
      req(4'h0, 32'h0000_0100, 32'h0);
      exp_v = sb.pop_front(); vectors++;
      if (rdata !== exp_v) begin errors++; $display("FAIL ram_lanes: got %h want %h", rdata, exp_v); end
   endtask

   task automatic test_alias_read_first;
      req(4'hF, 32'h0000_4000, 32'hDEAD_BEEF);
      sb.push_back(32'hDEAD_BEEF);
      req(4'h0, 32'h0000_0000, 32'h0);
      exp_v = sb.pop_front(); vectors++;
      if (rdata !== exp_v) begin errors++; $display("FAIL alias: got %h want %h", rdata, exp_v); end
      sb.push_back(32'hDEAD_BEEF);
      req(4'hF, 32'h0000_0000, 32'h1234_5678);
      exp_v = sb.pop_front(); vectors++;
      if (rdata !== exp_v) begin errors++; $display("FAIL read_first: got %h want %h", rdata, exp_v); end
      sb.push_back(32'h1234_5678);
      req(4'h0, 32'h0000_0000, 32'h0);
      exp_v = sb.pop_front(); vectors++;
      if (rdata !== exp_v) begin errors++; $display("FAIL back_to_back: got %h want %h", rdata, exp_v); end
   endtask

   task automatic test_io;
      req(4'hF, IO | 32'h00, 32'hFFFF_00A5);
      vectors++;
      if (led !== 16'h00A5) begin errors++; $display("FAIL led_write: got %h want %h", led, 16'h00A5); end
      req(4'b0011, IO | 32'h00, 32'h0000_5A5A);
      vectors++;
      if (led !== 16'h00A5) begin errors++; $display("FAIL led_partial: got %h want %h", led, 16'h00A5); end
      sb.push_back(32'h0000_00A5);
      req(4'h0, IO | 32'h00, 32'h0);
      exp_v = sb.pop_front(); vectors++;
      if (rdata !== exp_v) begin errors++; $display("FAIL led_read: got %h want %h", rdata, exp_v); end
      sw = 8'h3C;
      sb.push_back(32'h0000_003C);
      req(4'h0, IO | 32'h04, 32'h0);
      exp_v = sb.pop_front(); vectors++;
      if (rdata !== exp_v) begin errors++; $display("FAIL sw_read: got %h want %h", rdata, exp_v); end
      sb.push_back(32'h0);
      req(4'h0, IO | 32'h40, 32'h0);
      exp_v = sb.pop_front(); vectors++;
      if (rdata !== exp_v) begin errors++; $display("FAIL unmapped: got %h want %h", rdata, exp_v); end
   endtask

   task automatic test_timer_irq;
      req(4'hF, IO | 32'h08, 32'h0);
      req(4'hF, IO | 32'h0C, 32'h5);
      req(4'hF, IO | 32'h10, 32'h3);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         vectors++;
         if (int_req !== (k == 6)) begin
            errors++; $display("FAIL irq_rise_cycle%0d: got %b want %b", k, int_req, (k == 6));
         end
      end
      req(4'hF, IO | 32'h14, 32'h1);
      vectors++;
      if (int_req !== 1'b0) begin errors++; $display("FAIL irq_w1c: got %b want 0", int_req); end
      req(4'hF, IO | 32'h10, 32'h0);
   endtask

   task automatic test_timer_wrap;
      req(4'hF, IO | 32'h10, 32'h1);
      req(4'hF, IO | 32'h08, 32'hFFFF_FFFE);
      for (int k = 0; k < 3; k++) begin
         sb.push_back(32'hFFFF_FFFE + 32'(k));
         req(4'h0, IO | 32'h08, 32'h0);
         exp_v = sb.pop_front(); vectors++;
         if (rdata !== exp_v) begin errors++; $display("FAIL tcount_wrap%0d: got %h want %h", k, rdata, exp_v); end
      end
      req(4'hF, IO | 32'h10, 32'h0);
   endtask

   task automatic test_w1c_match;
      req(4'hF, IO | 32'h14, 32'h1);
      sb.push_back(32'h0);
      req(4'h0, IO | 32'h14, 32'h0);
      exp_v = sb.pop_front(); vectors++;
      if (rdata !== exp_v) begin errors++; $display("FAIL stat_clear: got %h want %h", rdata, exp_v); end
      req(4'hF, IO | 32'h08, 32'd10);
      req(4'hF, IO | 32'h0C, 32'd10);
      req(4'hF, IO | 32'h10, 32'h1);
      req(4'hF, IO | 32'h14, 32'h1);   // issued in the match cycle
      sb.push_back(32'h1);
      req(4'h0, IO | 32'h14, 32'h0);
      exp_v = sb.pop_front(); vectors++;
      if (rdata !== exp_v) begin errors++; $display("FAIL w1c_vs_match: got %h want %h", rdata, exp_v); end
   endtask

   task automatic test_mid_reset;
      req(4'hF, IO | 32'h10, 32'h0);
      req(4'hF, IO | 32'h14, 32'h1);
      req(4'hF, IO | 32'h08, 32'h0);
      req(4'hF, IO | 32'h0C, 32'h2);
      req(4'hF, IO | 32'h10, 32'h3);
      idle(5);
      vectors++;
      if (int_req !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want 1", int_req); end
      req(4'hF, IO | 32'h00, 32'h0000_1234);
      req(4'hF, 32'h0000_0200, 32'hCAFE_F00D);
      sb.push_back(32'hCAFE_F00D);
      req(4'h0, 32'h0000_0200, 32'h0);
      exp_v = sb.pop_front(); vectors++;
      if (rdata !== exp_v) begin errors++; $display("FAIL pre_reset_read: got %h want %h", rdata, exp_v); end
      rst = 1'b1;
      sb.push_back(32'h0);
      req(4'hF, 32'h0000_0200, 32'h0BAD_BEEF);
      rst = 1'b0;
      exp_v = sb.pop_front(); vectors++;
      if (rdata !== exp_v) begin errors++; $display("FAIL rst_rdata: got %h want %h", rdata, exp_v); end
      vectors++;
      if (led !== 16'h0) begin errors++; $display("FAIL rst_led: got %h want %h", led, 16'h0); end
      vectors++;
      if (int_req !== 1'b0) begin errors++; $display("FAIL rst_int: got %b want 0", int_req); end
      sb.push_back(32'hCAFE_F00D);
      req(4'h0, 32'h0000_0200, 32'h0);
      exp_v = sb.pop_front(); vectors++;
      if (rdata !== exp_v) begin errors++; $display("FAIL rst_dropped_write: got %h want %h", rdata, exp_v); end
      idle(3);
      vectors++;
      if (int_req !== 1'b0) begin errors++; $display("FAIL rst_timer_stopped: got %b want 0", int_req); end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0; sw = 8'h00;
      @(posedge clk); #1;
      test_reset();
      test_ram_lanes();
      test_alias_read_first();
      test_io();
      test_timer_irq();
      test_timer_wrap();
      test_w1c_match();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
